// File: rtl/haraka_pkg.sv
// Shared definitions for the Haraka-512 controller: FSM states, round constants
// and the lane selection used to truncate the 512-bit result to a 256-bit digest.
package haraka_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int RC_ROUNDS = 5;
    localparam int R_W       = 3;

    // Digest is {L6, L4, L3, L1}, most significant lane first.
    localparam int LANE_D3 = 6;
    localparam int LANE_D2 = 4;
    localparam int LANE_D1 = 3;
    localparam int LANE_D0 = 1;

    localparam logic [0:39][127:0] RC_TABLE = {
        128'h0684704ce620c00ab2c5fef075817b9d, 128'h8b66b4e188f3a06b640f6ba42f08f717,
        128'h3402de2d53f28498cf029d609f029114, 128'h0ed6eae62e7b4f08bbf3bcaffd5b4f79,
        128'hcbcfb0cb4872448b79eecd1cbe397044, 128'h7eeacdee6e9032b78d5335ed2b8a057b,
        128'h67c28f435e2e7cd0e2412761da4fef1b, 128'h2924d9b0afcacc07675ffde21fc70b3b,
        128'hab4d63f1e6867fe9ecdb8fcab9d465ee, 128'h1c30bf84d4b7cd645b2a404fad037e33,
        128'hb2cc0bb9941723bf69028b2e8df69800, 128'hfa0478a6de6f55724aaa9ec85c9d2d8a,
        128'hdfb49f2b6b772a120efa4f2e29129fd4, 128'h1ea10344f449a23632d611aebb6a12ee,
        128'haf0449884b0500845f9600c99ca8eca6, 128'h21025ed89d199c4f78a2c7e327e593ec,
        128'hbf3aaaf8a759c9b7b9282ecd82d40173, 128'h6260700d6186b01737f2efd910307d6b,
        128'h5aca45c22130044381c29153f6fc9ac6, 128'h9223973c226b68bb2caf92e836d1943a,
        128'hd3bf9238225886eb6cbab958e51071b4, 128'hdb863ce5aef0c677933dfddd24e1128d,
        128'hbb606268ffeba09c83e48de3cb2212b1, 128'h734bd3dce2e4d19c2db91a4ec72bf77d,
        128'h43bb47c361301b434b1415c42cb3924e, 128'hdba775a8e707eff603b231dd16eb6899,
        128'h6df3614b3c7559778e5e23027eca472c, 128'hcda75a17d6de7d776d1be5b9b88617f9,
        128'hec6b43f06ba8e9aa9d6c069da946ee5d, 128'hcb1e6950f957332ba25311593bf327c1,
        128'h2cee0c7500da619ce4ed0353600ed0d9, 128'hf0b1a5a196e90cab80bbbabc63a4a350,
        128'hae3db1025e962988ab0dde30938dca39, 128'h17bb8f38d554a40b8814f3a82e75b442,
        128'h34bb8a5b5f427fd7aeb6b779360a16f6, 128'h26f65241cbe5543843ce5918ffbaafde,
        128'h4ce99a54b9f3026aa2ca9cf7839ec978, 128'hae51a51a1bdff7be40c06e2822901235,
        128'ha0c1613cba7ed22bc173bc0f48a659cf, 128'h756acc03022882884ad6bdfde9c59da1
    };

    function automatic logic [255:0] haraka_trunc(input logic [511:0] y);
        return {y[64*LANE_D3 +: 64], y[64*LANE_D2 +: 64],
                y[64*LANE_D1 +: 64], y[64*LANE_D0 +: 64]};
    endfunction

endpackage

// File: rtl/haraka_rc_rom.sv
// Combinational lookup of the eight 128-bit round constants for round index r.
module haraka_rc_rom
    import haraka_pkg::*;
(
    input  logic [R_W-1:0]      r,
    output logic [0:7][127:0]   rc
);

    logic [R_W-1:0] rs;
    logic [5:0]     idx;

    always_comb begin
        rs  = (r > R_W'(RC_ROUNDS - 1)) ? R_W'(RC_ROUNDS - 1) : r;
        idx = '0;
        rc  = '0;
        for (int k = 0; k < 8; k++) begin
            idx   = {rs, 3'(k)};
            rc[k] = RC_TABLE[idx];
        end
    end

endmodule

// File: rtl/haraka512_ctrl.sv
// Haraka-512 sequencer: captures a message, steps an external permutation core
// through NUM_ROUNDS rounds, then applies feed-forward and truncation.
module haraka512_ctrl
    import haraka_pkg::*;
#(
    parameter int NUM_ROUNDS = 5,
    parameter int ROUND_LAT  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [511:0]        s_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [255:0]        m_digest,
    output logic [511:0]        core_in,
    output logic [0:7][127:0]   core_rc,
    output logic                core_sel,
    output logic                core_encrypt,
    input  logic [511:0]        core_out
);

    localparam int LAST = NUM_ROUNDS * ROUND_LAT;
    localparam int CW   = $clog2(LAST + 1);

    state_t           state;
    logic [CW-1:0]    c;
    logic [511:0]     x_reg;
    logic [R_W-1:0]   r;
    logic [0:7][127:0] rom_rc;
    logic [511:0]     y;
    logic             run;
    logic             at_last;
    int               q;
    logic             unused_lanes;

    assign run     = (state == RUN);
    assign at_last = (c == CW'(LAST));

    // Round index follows the cycle counter; the final routing cycle reuses the last round.
    always_comb begin
        q = int'(c) / ROUND_LAT;
        if (q > NUM_ROUNDS - 1) q = NUM_ROUNDS - 1;
        r = R_W'(q);
    end

    haraka_rc_rom u_rc_rom (
        .r  (r),
        .rc (rom_rc)
    );

    assign core_in      = x_reg;
    assign core_rc      = run ? rom_rc : '0;
    assign core_encrypt = run;
    assign core_sel     = !(run && (c == '0 || at_last));

    assign y            = core_out ^ x_reg;
    assign unused_lanes = ^{y[511:448], y[383:320], y[191:128], y[63:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            c        <= '0;
            x_reg    <= '0;
            m_digest <= '0;
            m_valid  <= 1'b0;
            s_ready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    s_ready <= 1'b1;
                    if (s_valid && s_ready) begin
                        x_reg   <= s_data;
                        c       <= '0;
                        s_ready <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (at_last) begin
                        m_digest <= haraka_trunc(y);
                        m_valid  <= 1'b1;
                        c        <= '0;
                        state    <= DONE;
                    end else begin
                        c <= c + 1'b1;
                    end
                end
                DONE: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        s_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/haraka512_ctrl.md
HARAKA512_CTRL -- requirements
Module: haraka512_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 5, number of permutation rounds per message.
REQ-002 Parameter ROUND_LAT, default 2, core cycles from launch of one round to its result on the core output or feedback path.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 s_valid  in  1, s_ready  out  1, s_data  in  512: 512-bit message input handshake.
REQ-006 m_valid  out  1, m_ready  in  1, m_digest  out  256: digest output handshake.
REQ-007 core_in  out  512  message to the permutation core's direct input.
REQ-008 core_rc  out  128 x [0:7]  round constants to the core.
REQ-009 core_sel  out  1  core mux/demux select; 0 = direct in/out, 1 = feedback.
REQ-010 core_encrypt  out  1  core encrypt enable.
REQ-011 core_out  in  512  permutation result from the core.

Function
REQ-012 FSM states IDLE, RUN, DONE; s_ready SHALL be 1 only in IDLE, with no overlap of messages.
REQ-013 IDLE: on s_valid && s_ready, s_data SHALL be captured into x_reg, core_in SHALL present x_reg from the next cycle, and the cycle counter c SHALL be cleared as the FSM enters RUN.
REQ-014 RUN: c SHALL increment each cycle from 0 to NUM_ROUNDS*ROUND_LAT; round index r = c / ROUND_LAT, saturated at NUM_ROUNDS-1.
REQ-015 core_sel SHALL be 0 at c = 0 (launch from core_in) and at c = NUM_ROUNDS*ROUND_LAT (result routed to core_out), and 1 at every other RUN cycle and in IDLE/DONE.
REQ-016 core_rc[k] SHALL equal RC_TABLE[8*r + k] throughout RUN, and zero outside RUN.
REQ-017 core_encrypt SHALL be 1 in RUN and 0 otherwise.
REQ-018 At c = NUM_ROUNDS*ROUND_LAT, y = core_out XOR x_reg SHALL be computed and the FSM SHALL go to DONE.
REQ-019 With lane Lk = y[64k+63:64k], the registered m_digest SHALL be {L6, L4, L3, L1}.
REQ-020 m_valid SHALL be 1 in DONE; m_digest SHALL stay stable while m_valid && !m_ready.
REQ-021 On m_valid && m_ready the FSM SHALL return to IDLE, with s_ready high the following cycle.
REQ-022 Latency from the accept cycle to the first m_valid cycle SHALL be NUM_ROUNDS*ROUND_LAT + 2 cycles (12 with defaults).
REQ-023 s_valid during RUN or DONE SHALL be ignored, and s_data SHALL not be sampled.
REQ-024 When m_ready is held low indefinitely, the FSM SHALL remain in DONE with m_valid high and m_digest unchanged.

Reset
REQ-025 While rst_n = 0: state = IDLE, c = 0, x_reg = 0, m_digest = 0, m_valid = 0, s_ready = 0, core_sel = 1, core_encrypt = 0, core_rc = 0, core_in = 0.
REQ-026 s_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-027 Reset asserted mid-RUN or in DONE SHALL abort the message with no m_valid pulse and no partial digest.

Structure
REQ-028 Shared package haraka_pkg SHALL hold RC_TABLE[0:39] (128-bit Haraka v2 constants), the FSM state enum, and the lane-truncation index constants.
REQ-029 Sub-module haraka_rc_rom SHALL map round index r to the 8 x 128 constant set, combinationally.

Verification
REQ-030 Bench: behavioural core stub that checks core_sel and core_rc at each c and returns a programmable core_out.
REQ-031 s_data = {8{64'h0123456789ABCDEF}}, core_out = all-ones -> m_digest = {4{64'hFEDCBA9876543210}}, with m_valid at accept+12.
REQ-032 Any accepted message -> core_sel = 0 exactly at c = 0 and c = 10; core_rc[0] = RC_TABLE[0], [8], [16], [24], [32] at c = 0, 2, 4, 6, 8.
REQ-033 m_ready low for 20 cycles after m_valid -> m_digest stable and s_ready = 0 throughout; s_valid pulses meanwhile are dropped.
REQ-034 rst_n pulsed low at c = 5 -> m_valid never asserts, and s_ready = 1 on the first clock edge after release.
REQ-035 Back-to-back messages with m_ready tied 1 -> accept-to-accept spacing of 13 cycles, and both digests correct.
